hamming_decoder_32: RTL

HAMMING_DECODER_32 -- requirements
Module: hamming_decoder_32

---
 rtl/hamming_pkg.sv | 38 +++
 rtl/hamming_syndrome_38.sv | 28 ++
 rtl/hamming_decoder_32.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
// Shared constants and helpers for the 32-bit Hamming SEC codec, used by
// both the encoder and the decoder.
//   DATA_W  : data word width (32)
//   CODE_W  : codeword width (38), bit k is Hamming position k+1
//   PAR_W   : number of parity / syndrome bits (6)
//   isParityPos(pos) : 1 when Hamming position pos (1-based) holds parity
//   extractData(code): gathers d0..d31 from the non-parity positions
// ---------------------------------------------------------------------------
package hamming_pkg;

  localparam int DATA_W = 32;
  localparam int CODE_W = 38;
  localparam int PAR_W  = 6;

  // Parity bits live at the power-of-two positions 1, 2, 4, 8, 16, 32.
  function automatic logic isParityPos(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bits fill the remaining positions in ascending order, so walking
  // the positions upward and skipping parity slots yields d0, d1, ... d31.
  function automatic logic [DATA_W-1:0] extractData(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] data;
    int k;
    data = '0;
    k    = 0;
    for (int j = 1; j <= CODE_W; j++) begin
      if (!isParityPos(j)) begin
        data[k] = code[j-1];
        k       = k + 1;
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/hamming_syndrome_38.sv
// ---------------------------------------------------------------------------
// hamming_syndrome_38
// Purely combinational syndrome generator for the 38-bit Hamming codeword.
//   i_code     [37:0] : codeword, bit k is Hamming position k+1
//   o_syndrome [5:0]  : syndrome; bit i is the XOR of every code bit whose
//                       position has bit i set
// ---------------------------------------------------------------------------
module hamming_syndrome_38
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [PAR_W-1:0]  o_syndrome
);

  // Each syndrome bit checks the group of positions sharing that binary
  // weight; a single flipped bit therefore reports its own position.
  always_comb begin
    o_syndrome = '0;
    for (int i = 0; i < PAR_W; i++) begin
      for (int j = 0; j < CODE_W; j++) begin
        if (((j + 1) & (1 << i)) != 0) begin
          o_syndrome[i] = o_syndrome[i] ^ i_code[j];
        end
      end
    end
  end

endmodule

// File: rtl/hamming_decoder_32.sv
// ---------------------------------------------------------------------------
// hamming_decoder_32
// Two-stage pipelined Hamming SEC decoder with valid/ready handshakes on
// both sides. Stage 1 registers the codeword and its syndrome, stage 2
// registers the corrected data, syndrome and flags that drive out_*.
//
// Optional feature macro: HAMMING_DEC_ERR_CNT_EN
//   defined   : saturating corrected/uncorrectable counters with cnt_clr
//   undefined : counters absent, err_cnt_* tied to 0, cnt_clr ignored
//
// Parameters
//   CNT_W : width of each error counter
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : input handshake
//   in_code  [37:0] : codeword, bit k is Hamming position k+1
//   out_valid/ready : output handshake
//   out_data [31:0] : corrected data word
//   out_syndrome[5:0]: computed syndrome
//   out_corrected   : a single-bit correction was applied
//   out_uncorr      : syndrome out of range, error uncorrectable
//   cnt_clr         : synchronous clear of both counters
//   err_cnt_corr/err_cnt_uncorr [CNT_W-1:0] : error counters
// ---------------------------------------------------------------------------
module hamming_decoder_32
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt_corr,
  output logic [CNT_W-1:0]  err_cnt_uncorr
);

  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CODE_W);

  logic              r_s1Valid;
  logic [CODE_W-1:0] r_s1Code;
  logic [PAR_W-1:0]  r_s1Syn;

  logic              r_s2Valid;
  logic [DATA_W-1:0] r_s2Data;
  logic [PAR_W-1:0]  r_s2Syn;
  logic              r_s2Corr;
  logic              r_s2Uncorr;

  logic [PAR_W-1:0]  w_inSyn;
  logic              w_adv2;
  logic              w_s1Corr;
  logic              w_s1Uncorr;
  logic [CODE_W-1:0] w_flipMask;
  logic [CODE_W-1:0] w_fixedCode;
  logic [DATA_W-1:0] w_s1Data;

  hamming_syndrome_38 u_syndrome (
    .i_code     (in_code),
    .o_syndrome (w_inSyn)
  );

  // Stage 2 can take a new beat when empty or when its beat leaves this
  // cycle; stage 1 likewise drains into stage 2, so in_ready depends only
  // on internal state and out_ready, never on in_valid.
  assign w_adv2   = !r_s2Valid || out_ready;
  assign in_ready = !r_s1Valid || w_adv2;

  // A syndrome inside 1..38 names the flipped position (parity positions
  // included); anything larger cannot come from a single error.
  assign w_s1Corr    = (r_s1Syn != '0) && (r_s1Syn <= MAX_POS);
  assign w_s1Uncorr  = (r_s1Syn > MAX_POS);
  assign w_flipMask  = w_s1Corr ? (CODE_W'(1) << (r_s1Syn - PAR_W'(1))) : '0;
  assign w_fixedCode = r_s1Code ^ w_flipMask;
  assign w_s1Data    = extractData(w_fixedCode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Code  <= '0;
      r_s1Syn   <= '0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Code <= in_code;
        r_s1Syn  <= w_inSyn;
      end
    end
  end

  // Stage 2 only loads on advance, so out_* stay frozen under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2Valid  <= 1'b0;
      r_s2Data   <= '0;
      r_s2Syn    <= '0;
      r_s2Corr   <= 1'b0;
      r_s2Uncorr <= 1'b0;
    end else if (w_adv2) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Data   <= w_s1Data;
        r_s2Syn    <= r_s1Syn;
        r_s2Corr   <= w_s1Corr;
        r_s2Uncorr <= w_s1Uncorr;
      end
    end
  end

  assign out_valid     = r_s2Valid;
  assign out_data      = r_s2Data;
  assign out_syndrome  = r_s2Syn;
  assign out_corrected = r_s2Corr;
  assign out_uncorr    = r_s2Uncorr;

`ifdef HAMMING_DEC_ERR_CNT_EN
  logic [CNT_W-1:0] r_cntCorr;
  logic [CNT_W-1:0] r_cntUncorr;
  logic             w_outXfer;

  assign w_outXfer = r_s2Valid && out_ready;

  // Counters only move on an actual output transfer and stick at all-ones;
  // a clear wins over an increment landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cntCorr   <= '0;
      r_cntUncorr <= '0;
    end else if (cnt_clr) begin
      r_cntCorr   <= '0;
      r_cntUncorr <= '0;
    end else if (w_outXfer) begin
      if (r_s2Corr && (r_cntCorr != '1)) begin
        r_cntCorr <= r_cntCorr + CNT_W'(1);
      end
      if (r_s2Uncorr && (r_cntUncorr != '1)) begin
        r_cntUncorr <= r_cntUncorr + CNT_W'(1);
      end
    end
  end

  assign err_cnt_corr   = r_cntCorr;
  assign err_cnt_uncorr = r_cntUncorr;
`else
  logic w_unusedCntClr;

  assign w_unusedCntClr = cnt_clr;
  assign err_cnt_corr   = '0;
  assign err_cnt_uncorr = '0;
`endif

endmodule
